calc_gravity_stream: RTL and testbench



---
 rtl/calc_gravity_stream_pkg.sv | 42 ++++
 rtl/calc_gravity_stream_grav_ch_accum.sv | 79 +++++++
 rtl/calc_gravity_stream.sv | 210 +++++++++++++++++++++
 tb/tb_calc_gravity_stream.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_gravity_stream_pkg.sv
// Shared types, default widths and saturating arithmetic for the centre-of-gravity accumulator.
// Pure declarations: no latency, no flow control.
package calc_gravity_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int SUM_S_WIDTH_DEF  = 28;
    localparam int SUM_SX_WIDTH_DEF = 40;
    localparam int SUM_SY_WIDTH_DEF = 40;
    localparam int IMG_WIDTH_DEF    = 640;
    localparam int IMG_HEIGHT_DEF   = 480;
    localparam int XW               = $clog2(IMG_WIDTH_DEF);
    localparam int YW               = $clog2(IMG_HEIGHT_DEF);

    typedef struct packed {
        logic [63:0] val;
        logic        ovf;
    } sat_t;

    // Unsigned add clamped to a w-bit all-ones ceiling (w <= 64).
    function automatic sat_t sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] sum;
        logic [64:0] lim;
        sat_t        r;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        if (sum > lim) begin
            r.val = 64'(lim);
            r.ovf = 1'b1;
        end else begin
            r.val = 64'(sum);
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_gravity_stream_grav_ch_accum.sv
// One channel: pixel weight (stage 1) then saturating S / S*x / S*y accumulation (stage 2), sticky ovf.
// Latency 2 cycles from pixel to accumulator; no backpressure, the owner gates en and clears with clr.
module grav_ch_accum
    import calc_gravity_stream_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int XBITS       = XW,
    parameter int YBITS       = YW,
    parameter int S_W         = SUM_S_WIDTH_DEF,
    parameter int SX_W        = SUM_SX_WIDTH_DEF,
    parameter int SY_W        = SUM_SY_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [PIXEL_WIDTH-1:0] pix,
    input  logic [PIXEL_WIDTH-1:0] thr,
    input  logic                   mode,
    input  logic [XBITS-1:0]       x,
    input  logic [YBITS-1:0]       y,
    output logic [S_W-1:0]         sum_s,
    output logic [SX_W-1:0]        sum_sx,
    output logic [SY_W-1:0]        sum_sy,
    output logic                   ovf
);

    logic [PIXEL_WIDTH-1:0] w;
    logic [PIXEL_WIDTH-1:0] w_q;
    logic [XBITS-1:0]       x_q;
    logic [YBITS-1:0]       y_q;
    logic                   vld_q;
    sat_t                   s_n;
    sat_t                   sx_n;
    sat_t                   sy_n;

    always_comb begin
        w = '0;
        if (pix > thr) begin
            w = mode ? pix - thr : PIXEL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            w_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            vld_q <= en;
            w_q   <= w;
            x_q   <= x;
            y_q   <= y;
        end
    end

    always_comb begin
        s_n  = sat_add(64'(sum_s), 64'(w_q), S_W);
        sx_n = sat_add(64'(sum_sx), 64'(w_q) * 64'(x_q), SX_W);
        sy_n = sat_add(64'(sum_sy), 64'(w_q) * 64'(y_q), SY_W);
    end

    // clr wins over a pending stage-1 pixel: on a restart that pixel belongs to the abandoned frame.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum_s  <= '0;
            sum_sx <= '0;
            sum_sy <= '0;
            ovf    <= 1'b0;
        end else if (vld_q) begin
            sum_s  <= S_W'(s_n.val);
            sum_sx <= SX_W'(sx_n.val);
            sum_sy <= SY_W'(sy_n.val);
            ovf    <= ovf | s_n.ovf | sx_n.ovf | sy_n.ovf;
        end
    end

endmodule

// File: rtl/calc_gravity_stream.sv
// Streaming per-channel centre-of-gravity sums with raster counters and frame FSM; ROI window when CALC_GRAVITY_ROI_EN is defined.
// Result valid 3 cycles after the last pixel and held until iRES_READY; frames starting during FLUSH/HOLD are dropped (oDROP).
module calc_gravity_stream
    import calc_gravity_stream_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMG_WIDTH    = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT   = IMG_HEIGHT_DEF,
    parameter int SUM_S_WIDTH  = SUM_S_WIDTH_DEF,
    parameter int SUM_SX_WIDTH = SUM_SX_WIDTH_DEF,
    parameter int SUM_SY_WIDTH = SUM_SY_WIDTH_DEF
) (
    input  logic                           CCLK,
    input  logic                           RST,
    input  logic [PIXEL_WIDTH-1:0]         iTHRESHOLD,
    input  logic                           iMODE,
    input  logic                           iFRAME_START,
    input  logic                           iPIX_VALID,
    input  logic [NUM_CH*PIXEL_WIDTH-1:0]  iPIX_DATA,
`ifdef CALC_GRAVITY_ROI_EN
    input  logic [$clog2(IMG_WIDTH)-1:0]   iROI_X0,
    input  logic [$clog2(IMG_WIDTH)-1:0]   iROI_X1,
    input  logic [$clog2(IMG_HEIGHT)-1:0]  iROI_Y0,
    input  logic [$clog2(IMG_HEIGHT)-1:0]  iROI_Y1,
`endif
    output logic                           oRES_VALID,
    input  logic                           iRES_READY,
    output logic [NUM_CH*SUM_S_WIDTH-1:0]  oSUM_S,
    output logic [NUM_CH*SUM_SX_WIDTH-1:0] oSUM_SX,
    output logic [NUM_CH*SUM_SY_WIDTH-1:0] oSUM_SY,
    output logic [NUM_CH-1:0]              oOVF,
    output logic                           oDROP,
    output logic [1:0]                     oSTATE
);

    localparam int XBITS = $clog2(IMG_WIDTH);
    localparam int YBITS = $clog2(IMG_HEIGHT);
    localparam logic [XBITS-1:0] X_LAST = XBITS'(IMG_WIDTH - 1);
    localparam logic [YBITS-1:0] Y_LAST = YBITS'(IMG_HEIGHT - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic                   flush_cnt;
    logic [XBITS-1:0]       x_cnt;
    logic [YBITS-1:0]       y_cnt;
    logic [XBITS-1:0]       px;
    logic [YBITS-1:0]       py;
    logic [PIXEL_WIDTH-1:0] thr_q;
    logic [PIXEL_WIDTH-1:0] thr_eff;
    logic                   mode_q;
    logic                   mode_eff;
    logic                   start;
    logic                   take;
    logic                   last;
    logic                   accept;
    logic                   clr;
    logic                   roi_ok;
    logic                   drop_q;

    // A start pulse takes effect in its own cycle, so a same-cycle pixel sees (0,0) and the new thr/mode.
    always_comb begin
        start    = iFRAME_START && (state == IDLE || state == ACCUM);
        take     = iPIX_VALID && (state == ACCUM || start);
        px       = start ? '0 : x_cnt;
        py       = start ? '0 : y_cnt;
        thr_eff  = start ? iTHRESHOLD : thr_q;
        mode_eff = start ? iMODE : mode_q;
        last     = take && (px == X_LAST) && (py == Y_LAST);
        accept   = (state == HOLD) && iRES_READY;
        clr      = start || accept;
    end

`ifdef CALC_GRAVITY_ROI_EN
    logic [XBITS-1:0] rx0_q, rx1_q, rx0, rx1;
    logic [YBITS-1:0] ry0_q, ry1_q, ry0, ry1;

    always_ff @(posedge CCLK) begin
        if (RST) begin
            rx0_q <= '0;
            rx1_q <= '0;
            ry0_q <= '0;
            ry1_q <= '0;
        end else if (start) begin
            rx0_q <= iROI_X0;
            rx1_q <= iROI_X1;
            ry0_q <= iROI_Y0;
            ry1_q <= iROI_Y1;
        end
    end

    always_comb begin
        rx0    = start ? iROI_X0 : rx0_q;
        rx1    = start ? iROI_X1 : rx1_q;
        ry0    = start ? iROI_Y0 : ry0_q;
        ry1    = start ? iROI_Y1 : ry1_q;
        roi_ok = (px >= rx0) && (px <= rx1) && (py >= ry0) && (py <= ry1);
    end
`else
    assign roi_ok = 1'b1;
`endif

    always_ff @(posedge CCLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (last) begin
                    state_nxt = FLUSH;
                end else if (start) begin
                    state_nxt = ACCUM;
                end
            end
            FLUSH:   if (flush_cnt) state_nxt = HOLD;
            HOLD:    if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CCLK) begin
        if (RST || state != FLUSH) begin
            flush_cnt <= 1'b0;
        end else begin
            flush_cnt <= ~flush_cnt;
        end
    end

    always_ff @(posedge CCLK) begin
        if (RST) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            thr_q  <= '0;
            mode_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= iFRAME_START && (state != IDLE);
            if (start) begin
                thr_q  <= iTHRESHOLD;
                mode_q <= iMODE;
            end
            if (take) begin
                if (px == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (py == Y_LAST) ? '0 : py + YBITS'(1);
                end else begin
                    x_cnt <= px + XBITS'(1);
                    y_cnt <= py;
                end
            end else if (start) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end
        end
    end

    logic [SUM_S_WIDTH-1:0]  s_arr   [NUM_CH];
    logic [SUM_SX_WIDTH-1:0] sx_arr  [NUM_CH];
    logic [SUM_SY_WIDTH-1:0] sy_arr  [NUM_CH];
    logic                    ovf_arr [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        grav_ch_accum #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .XBITS       (XBITS),
            .YBITS       (YBITS),
            .S_W         (SUM_S_WIDTH),
            .SX_W        (SUM_SX_WIDTH),
            .SY_W        (SUM_SY_WIDTH)
        ) u_ch (
            .clk    (CCLK),
            .rst    (RST),
            .clr    (clr),
            .en     (take && roi_ok),
            .pix    (iPIX_DATA[c*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .thr    (thr_eff),
            .mode   (mode_eff),
            .x      (px),
            .y      (py),
            .sum_s  (s_arr[c]),
            .sum_sx (sx_arr[c]),
            .sum_sy (sy_arr[c]),
            .ovf    (ovf_arr[c])
        );
    end

    always_comb begin
        oSUM_S  = '0;
        oSUM_SX = '0;
        oSUM_SY = '0;
        oOVF    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            oSUM_S[c*SUM_S_WIDTH +: SUM_S_WIDTH]    = s_arr[c];
            oSUM_SX[c*SUM_SX_WIDTH +: SUM_SX_WIDTH] = sx_arr[c];
            oSUM_SY[c*SUM_SY_WIDTH +: SUM_SY_WIDTH] = sy_arr[c];
            oOVF[c]                                 = ovf_arr[c];
        end
    end

    assign oRES_VALID = (state == HOLD);
    assign oDROP      = drop_q;
    assign oSTATE     = state;

endmodule

// File: tb/tb_calc_gravity_stream.sv
// Directed bench: 4x4 raster, two DUTs (S width 28 and 4) checked every result cycle against a frame-level model.
module tb_calc_gravity_stream;

    localparam int NCH = 2;
    localparam int PW  = 8;
    localparam int IW  = 4;
    localparam int IH  = 4;
    localparam int SW  = 28;
    localparam int SSW = 4;
    localparam int SXW = 40;
    localparam int SYW = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [PW-1:0]    thr;
    logic             mode;
    logic             fs;
    logic             pv;
    logic [NCH*PW-1:0] pdat;
    logic             rdy;
    logic [1:0]       rx0, rx1, ry0, ry1;

    logic               m_vld, s_vld, m_drop, s_drop;
    logic [NCH*SW-1:0]  m_s;
    logic [NCH*SSW-1:0] s_s;
    logic [NCH*SXW-1:0] m_sx, s_sx;
    logic [NCH*SYW-1:0] m_sy, s_sy;
    logic [NCH-1:0]     m_ovf, s_ovf;
    logic [1:0]         m_state, s_state;

    calc_gravity_stream #(.NUM_CH(NCH), .PIXEL_WIDTH(PW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
                          .SUM_S_WIDTH(SW), .SUM_SX_WIDTH(SXW), .SUM_SY_WIDTH(SYW)) u_main (
        .CCLK(clk), .RST(rst), .iTHRESHOLD(thr), .iMODE(mode), .iFRAME_START(fs),
        .iPIX_VALID(pv), .iPIX_DATA(pdat),
`ifdef CALC_GRAVITY_ROI_EN
        .iROI_X0(rx0), .iROI_X1(rx1), .iROI_Y0(ry0), .iROI_Y1(ry1),
`endif
        .oRES_VALID(m_vld), .iRES_READY(rdy), .oSUM_S(m_s), .oSUM_SX(m_sx), .oSUM_SY(m_sy),
        .oOVF(m_ovf), .oDROP(m_drop), .oSTATE(m_state));

    calc_gravity_stream #(.NUM_CH(NCH), .PIXEL_WIDTH(PW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
                          .SUM_S_WIDTH(SSW), .SUM_SX_WIDTH(SXW), .SUM_SY_WIDTH(SYW)) u_small (
        .CCLK(clk), .RST(rst), .iTHRESHOLD(thr), .iMODE(mode), .iFRAME_START(fs),
        .iPIX_VALID(pv), .iPIX_DATA(pdat),
`ifdef CALC_GRAVITY_ROI_EN
        .iROI_X0(rx0), .iROI_X1(rx1), .iROI_Y0(ry0), .iROI_Y1(ry1),
`endif
        .oRES_VALID(s_vld), .iRES_READY(rdy), .oSUM_S(s_s), .oSUM_SX(s_sx), .oSUM_SY(s_sy),
        .oOVF(s_ovf), .oDROP(s_drop), .oSTATE(s_state));

    typedef struct packed {
        logic [NCH-1:0][63:0] s;
        logic [NCH-1:0][63:0] sx;
        logic [NCH-1:0][63:0] sy;
    } exp_t;

    logic [PW-1:0] img [NCH][IH][IW];
    exp_t          exp_q[$];
    int            t_q[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_err = 0;
    int            drop_exp = 0;
    int            drop_m = 0;
    int            drop_s = 0;
    logic [63:0]   got_m_s [NCH], got_m_sx [NCH], got_m_sy [NCH];
    logic [63:0]   got_s_s [NCH];
    logic [NCH-1:0] got_m_ovf, got_s_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
        end
    endtask

    // Whole-frame reference: weight every pixel by the threshold rule and window, then sum.
    function automatic exp_t model_frame();
        exp_t e;
        e = '0;
        for (int c = 0; c < NCH; c++)
            for (int y = 0; y < IH; y++)
                for (int x = 0; x < IW; x++) begin
                    longint unsigned w;
                    int p;
                    p = int'(img[c][y][x]);
                    w = 0;
                    if (p > int'(thr)) w = mode ? longint'(p - int'(thr)) : 1;
`ifdef CALC_GRAVITY_ROI_EN
                    if (x < int'(rx0) || x > int'(rx1) || y < int'(ry0) || y > int'(ry1)) w = 0;
`endif
                    e.s[c]  = e.s[c] + w;
                    e.sx[c] = e.sx[c] + w * longint'(x);
                    e.sy[c] = e.sy[c] + w * longint'(y);
                end
        return e;
    endfunction

    task automatic cmp_ch(input string tag, input int c, input int sw, input logic [63:0] gs,
                          input logic [63:0] gsx, input logic [63:0] gsy, input logic gov, input exp_t e);
        logic [63:0] ms, mx, my;
        ms = (64'd1 << sw) - 64'd1;
        mx = (64'd1 << SXW) - 64'd1;
        my = (64'd1 << SYW) - 64'd1;
        chk($sformatf("%s_s%0d", tag, c),  gs,  (e.s[c]  > ms) ? ms : e.s[c]);
        chk($sformatf("%s_sx%0d", tag, c), gsx, (e.sx[c] > mx) ? mx : e.sx[c]);
        chk($sformatf("%s_sy%0d", tag, c), gsy, (e.sy[c] > my) ? my : e.sy[c]);
        chk($sformatf("%s_ovf%0d", tag, c), 64'(gov),
            64'((e.s[c] > ms) || (e.sx[c] > mx) || (e.sy[c] > my)));
    endtask

    // Compare process: every result-valid cycle against the model front, plus clear-after-accept.
    initial begin
        logic prev_vld;
        logic acc_prev;
        exp_t e;
        prev_vld = 1'b0;
        acc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 1'b0;
                acc_prev = 1'b0;
            end else begin
                if (m_drop) drop_m++;
                if (s_drop) drop_s++;
                if (acc_prev) begin
                    chk("clr_valid", 64'(m_vld | s_vld), 64'd0);
                    chk("clr_sums", 64'(|{m_s, m_sx, m_sy, s_s, s_sx, s_sy}), 64'd0);
                    chk("clr_ovf", 64'({m_ovf, s_ovf}), 64'd0);
                    acc_prev = 1'b0;
                end
                if (m_vld || s_vld) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 64'(m_vld | s_vld), 64'd0);
                    end else begin
                        e = exp_q[0];
                        chk("main_valid", 64'(m_vld), 64'd1);
                        chk("small_valid", 64'(s_vld), 64'd1);
                        if (!prev_vld) chk("latency", 64'(cyc), 64'(t_q[0] + 3));
                        for (int c = 0; c < NCH; c++) begin
                            cmp_ch("main", c, SW, 64'(m_s[c*SW +: SW]), 64'(m_sx[c*SXW +: SXW]),
                                   64'(m_sy[c*SYW +: SYW]), m_ovf[c], e);
                            cmp_ch("small", c, SSW, 64'(s_s[c*SSW +: SSW]), 64'(s_sx[c*SXW +: SXW]),
                                   64'(s_sy[c*SYW +: SYW]), s_ovf[c], e);
                        end
                        if (rdy) begin
                            for (int c = 0; c < NCH; c++) begin
                                got_m_s[c]  = 64'(m_s[c*SW +: SW]);
                                got_m_sx[c] = 64'(m_sx[c*SXW +: SXW]);
                                got_m_sy[c] = 64'(m_sy[c*SYW +: SYW]);
                                got_s_s[c]  = 64'(s_s[c*SSW +: SSW]);
                            end
                            got_m_ovf = m_ovf;
                            got_s_ovf = s_ovf;
                            void'(exp_q.pop_front());
                            void'(t_q.pop_front());
                            acc_prev = 1'b1;
                        end
                    end
                end
                prev_vld = m_vld;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_img(input logic [PW-1:0] v);
        for (int c = 0; c < NCH; c++)
            for (int y = 0; y < IH; y++)
                for (int x = 0; x < IW; x++) img[c][y][x] = v;
    endtask

    // Sends npix pixels in raster order; a full frame registers its expectation and last-pixel cycle.
    task automatic send_frame(input int npix, input bit same, input bit drop, input bit gap);
        if (drop) drop_exp++;
        if (!same) begin
            fs = 1'b1;
            pv = 1'b0;
            tick();
            fs = 1'b0;
        end
        for (int i = 0; i < npix; i++) begin
            fs   = same && (i == 0);
            pv   = 1'b1;
            pdat = {img[1][i/IW][i%IW], img[0][i/IW][i%IW]};
            if (i == IW*IH - 1) begin
                exp_q.push_back(model_frame());
                t_q.push_back(cyc);
            end
            tick();
            if (gap && (i % 5 == 2) && (i != npix - 1)) begin
                fs = 1'b0;
                pv = 1'b0;
                pdat = '1;
                tick();
            end
        end
        fs = 1'b0;
        pv = 1'b0;
        pdat = '0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("result_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            t_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; fs = 1'b0; pv = 1'b0; pdat = '0; rdy = 1'b0; thr = '0; mode = 1'b0;
        rx0 = 2'd0; rx1 = 2'd3; ry0 = 2'd0; ry1 = 2'd3;
        fill_img(8'd0);
        repeat (3) tick();
        chk("rst_state", 64'(m_state), 64'd0);
        chk("rst_valid", 64'(m_vld), 64'd0);
        chk("rst_drop", 64'(m_drop), 64'd0);
        chk("rst_sums", 64'(|{m_s, m_sx, m_sy, m_ovf}), 64'd0);
        chk("rst_small_state", 64'(s_state), 64'd0);
        rst = 1'b0;
        tick();

        // 1: binary, single pixel on ch0
        fill_img(8'd0); img[0][1][2] = 8'd200; thr = 8'd100; mode = 1'b0; rdy = 1'b1;
        send_frame(16, 0, 0, 1);
        wait_result();
        chk("t1_s0", got_m_s[0], 64'd1);
        chk("t1_sx0", got_m_sx[0], 64'd2);
        chk("t1_sy0", got_m_sy[0], 64'd1);
        chk("t1_ch1", got_m_s[1] | got_m_sx[1] | got_m_sy[1], 64'd0);

        // 2: weighted, start with same-cycle pixel
        fill_img(8'd0); img[1][0][1] = 8'd30; img[1][3][3] = 8'd20; thr = 8'd10; mode = 1'b1;
        send_frame(16, 1, 0, 0);
        wait_result();
        chk("t2_s1", got_m_s[1], 64'd30);
        chk("t2_sx1", got_m_sx[1], 64'd50);
        chk("t2_sy1", got_m_sy[1], 64'd30);
        chk("t2_small_s1", got_s_s[1], 64'd15);
        chk("t2_small_ovf", 64'(got_s_ovf), 64'd2);

        // 3: long hold, frame start while holding, accept together with a frame start
        fill_img(8'd0); img[0][2][3] = 8'd150; img[1][3][0] = 8'd255; img[1][1][1] = 8'd100;
        thr = 8'd100; mode = 1'b0; rdy = 1'b0;
        send_frame(16, 0, 0, 1);
        n = 0;
        while (!m_vld && n < 20) begin
            tick();
            n++;
        end
        chk("t3_in_hold", 64'(m_vld), 64'd1);
        repeat (5) tick();
        fs = 1'b1; drop_exp++;
        tick();
        fs = 1'b0;
        repeat (14) tick();
        chk("t3_still_hold", 64'(m_state), 64'd3);
        rdy = 1'b1; fs = 1'b1; drop_exp++;
        tick();
        fs = 1'b0;
        wait_result();
        tick();
        chk("t3_idle_after", 64'(m_state), 64'd0);
        chk("t3_s0", got_m_s[0], 64'd1);
        chk("t3_sx0", got_m_sx[0], 64'd3);
        chk("t3_sy1", got_m_sy[1], 64'd3);

        // 4: restart after 7 pixels
        fill_img(8'd200); thr = 8'd100; mode = 1'b0;
        send_frame(7, 0, 0, 0);
        fill_img(8'd0); img[0][3][1] = 8'd255; img[1][2][2] = 8'd101;
        send_frame(16, 1, 1, 1);
        wait_result();
        chk("t4_s0", got_m_s[0], 64'd1);
        chk("t4_sx0", got_m_sx[0], 64'd1);
        chk("t4_sy0", got_m_sy[0], 64'd3);
        chk("t4_sx1", got_m_sx[1], 64'd2);

        // 5: saturation on the narrow S accumulator
        fill_img(8'd255); thr = 8'd100; mode = 1'b0;
        send_frame(16, 0, 0, 0);
        wait_result();
        chk("t5_small_s0", got_s_s[0], 64'd15);
        chk("t5_small_ovf", 64'(got_s_ovf), 64'd3);
        chk("t5_main_s0", got_m_s[0], 64'd16);
        chk("t5_main_ovf", 64'(got_m_ovf), 64'd0);

        // 6: reset mid-frame, then a clean frame
        fill_img(8'd255);
        send_frame(9, 1, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        chk("t6_rst_state", 64'(m_state), 64'd0);
        chk("t6_rst_sums", 64'(|{m_s, m_sx, m_sy, s_s}), 64'd0);
        rst = 1'b0;
        tick();
        fill_img(8'd0); img[1][1][3] = 8'd255; thr = 8'd0; mode = 1'b1;
        send_frame(16, 0, 0, 1);
        wait_result();
        chk("t6_s1", got_m_s[1], 64'd255);
        chk("t6_sx1", got_m_sx[1], 64'd765);
        chk("t6_sy1", got_m_sy[1], 64'd255);
        chk("t6_s0", got_m_s[0], 64'd0);

`ifdef CALC_GRAVITY_ROI_EN
        fill_img(8'd255); thr = 8'd100; mode = 1'b0;
        rx0 = 2'd1; rx1 = 2'd2; ry0 = 2'd1; ry1 = 2'd2;
        send_frame(16, 0, 0, 0);
        wait_result();
        chk("roi_s0", got_m_s[0], 64'd4);
        chk("roi_sx0", got_m_sx[0], 64'd6);
        chk("roi_sy0", got_m_sy[0], 64'd6);
        rx0 = 2'd3; rx1 = 2'd1;
        send_frame(16, 1, 0, 0);
        wait_result();
        chk("roi_empty", got_m_s[0] | got_m_sx[0] | got_m_s[1], 64'd0);
        rx0 = 2'd0; rx1 = 2'd3; ry0 = 2'd0; ry1 = 2'd3;
`endif

        repeat (3) tick();
        chk("drop_count_main", 64'(drop_m), 64'(drop_exp));
        chk("drop_count_small", 64'(drop_s), 64'(drop_exp));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
